// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, branch flush (resolved in MEM), mem-busy freeze.
// Optional perf counters when HAZARD_PERF_EN is defined; control outputs are Mealy, forced to defaults in reset.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16
`ifdef HAZARD_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs2,
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_flush,
  output logic       pipe_freeze,
  output logic       timeout_err,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt_tot
`endif
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       load_use;
  logic       do_freeze;
  logic       do_flush;
  logic       do_stall;

  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  // In FLUSH the branch is already squashed in EX_MEM, so it must not re-flush.
  always_comb begin
    do_freeze = 1'b0;
    do_flush  = 1'b0;
    do_stall  = 1'b0;
    if (!reset) begin
      if (mem_busy)
        do_freeze = 1'b1;
      else if (branch_taken && (state != FLUSH))
        do_flush = 1'b1;
      else if (load_use)
        do_stall = 1'b1;
    end
  end

  assign pc_write    = !(do_freeze || do_stall);
  assign ifid_write  = !(do_freeze || do_stall);
  assign ifid_flush  = do_flush;
  assign idex_bubble = do_flush || do_stall;
  assign exmem_flush = do_flush;
  assign pipe_freeze = do_freeze;
  assign state_o     = state;

  assign wait_inc = (wait_cnt >= MAX_W) ? wait_cnt : wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else if (do_freeze) begin
      state <= MEM_WAIT;
      if (state == MEM_WAIT) begin
        wait_cnt <= wait_inc;
        if (wait_inc == MAX_W)
          timeout_err <= 1'b1;
      end else begin
        wait_cnt <= 8'd1;
        if (MAX_W == 8'd1)
          timeout_err <= 1'b1;
      end
    end else begin
      wait_cnt <= 8'd0;
      state    <= do_flush ? FLUSH : RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      wait_cnt_tot <= '0;
    end else begin
      if (do_stall)
        stall_cnt <= stall_cnt + 1'b1;
      if (do_flush)
        flush_cnt <= flush_cnt + 1'b1;
      if (state == MEM_WAIT)
        wait_cnt_tot <= wait_cnt_tot + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0, branch flush, mem-busy freeze, timeout, async reset.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_use_rs2, idex_memread, branch_taken, mem_busy;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze;
  logic       timeout_err;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, wait_cnt_tot;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze}
  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] FLSH  = 6'b111110;
  localparam logic [5:0] FRZ   = 6'b000001;

  hazard_ctrl #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs2(ifid_use_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .pipe_freeze(pipe_freeze),
    .timeout_err(timeout_err), .state_o(state_o)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt_tot(wait_cnt_tot)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] o, input logic [1:0] st, input logic to);
    check({tag, ".ctl"}, 32'({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze}), 32'(o));
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".timeout"}, 32'(timeout_err), 32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_use_rs2 = 1'b0;
    idex_memread = 1'b0; idex_rd = 5'd0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    @(negedge clk);
    check_outs("reset", NORM, 2'd0, 1'b0);
    #2 reset = 1'b0;
    step();

    // ld x5 ; add x6,x5,x1 -> one stall cycle
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd1; ifid_use_rs2 = 1'b1;
    @(negedge clk); check_outs("lu_rs1", STALL, 2'd0, 1'b0);
    step();
    idex_memread = 1'b0;
    @(negedge clk); check_outs("lu_after", NORM, 2'd0, 1'b0);
    step();

    // rs2 match only counts when the instruction reads rs2
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd1; ifid_rs2 = 5'd7; ifid_use_rs2 = 1'b1;
    @(negedge clk); check_outs("lu_rs2", STALL, 2'd0, 1'b0);
    ifid_use_rs2 = 1'b0;
    #1 check_outs("lu_rs2_unused", NORM, 2'd0, 1'b0);
    step();

    // x0 destination never stalls
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    @(negedge clk); check_outs("x0", NORM, 2'd0, 1'b0);
    step();

    // branch in RUN wins over load-use, then FLUSH honours load-use but ignores branch
    idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3; branch_taken = 1'b1;
    @(negedge clk); check_outs("br_run", FLSH, 2'd0, 1'b0);
    step();
    @(negedge clk); check_outs("br_flush_lu", STALL, 2'd2, 1'b0);
    idex_memread = 1'b0;
    #1 check_outs("br_flush_ign", NORM, 2'd2, 1'b0);
    step();
    clear_in();
    @(negedge clk); check_outs("br_back", NORM, 2'd0, 1'b0);
    step();

    // 3 busy cycles with pending branch, flush on the 4th
    mem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check_outs($sformatf("busy3_%0d", i), FRZ, (i == 0) ? 2'd0 : 2'd1, 1'b0);
      step();
    end
    mem_busy = 1'b0;
    @(negedge clk); check_outs("busy3_rel", FLSH, 2'd1, 1'b0);
    step();
    branch_taken = 1'b0;
    @(negedge clk); check_outs("busy3_flush", NORM, 2'd2, 1'b0);
    step();
    @(negedge clk); check_outs("busy3_run", NORM, 2'd0, 1'b0);
    step();

    // 20 busy cycles: timeout after the 16th, sticky afterwards
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); check_outs($sformatf("busy20_%0d", i), FRZ, (i == 0) ? 2'd0 : 2'd1, (i >= 16));
      step();
    end
    mem_busy = 1'b0;
    @(negedge clk); check_outs("busy20_rel", NORM, 2'd1, 1'b1);
    step();
    @(negedge clk); check_outs("busy20_sticky", NORM, 2'd0, 1'b1);
    step();

    // async reset in MEM_WAIT
    mem_busy = 1'b1;
    step();
    @(negedge clk); check_outs("pre_rst", FRZ, 2'd1, 1'b1);
    #1 reset = 1'b1;
    #1 check_outs("async_rst", NORM, 2'd0, 1'b0);
`ifdef HAZARD_PERF_EN
    check("perf_stall", stall_cnt, 32'd0);
    check("perf_flush", flush_cnt, 32'd0);
    check("perf_wait", wait_cnt_tot, 32'd0);
`endif
    #1 reset = 1'b0;
    mem_busy = 1'b0;
    step();
    @(negedge clk); check_outs("post_rst", NORM, 2'd0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
